// File: rtl/riscv_dram_arbiter_if.sv
// Bundle of the instruction-refill, data-refill/write-back and DRAM signals
// shared by the arbiter (slave modport) and its requesters/DRAM (master modport).
interface riscv_dram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_rd_req;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_rden;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_rden, mem_wren, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_rden, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/riscv_dram_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/write-backs onto one fixed-latency DRAM.
// Define RISCV_DRAM_ARB_RR_EN for round-robin between the I and D classes (default: fixed D > I).
module riscv_dram_arbiter #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_dram_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_DR,
        BUSY_DW,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t            state_reg;
    state_t            grant_next;
    logic [3:0]        cnt_reg;
    logic              mem_rden_reg;
    logic              mem_wren_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              i_ready_reg;
    logic              d_ready_reg;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
`ifdef RISCV_DRAM_ARB_RR_EN
    logic              last_grant_i_reg;
`endif

    // Winner of the next arbitration; IDLE means nothing is pending.
    always_comb begin
        grant_next = IDLE;
`ifdef RISCV_DRAM_ARB_RR_EN
        if (bus.i_req && (!(bus.d_wr_req || bus.d_rd_req) || !last_grant_i_reg))
            grant_next = BUSY_I;
        else if (bus.d_wr_req)
            grant_next = BUSY_DW;
        else if (bus.d_rd_req)
            grant_next = BUSY_DR;
`else
        if (bus.d_wr_req)
            grant_next = BUSY_DW;
        else if (bus.d_rd_req)
            grant_next = BUSY_DR;
        else if (bus.i_req)
            grant_next = BUSY_I;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mem_rden_reg  <= 1'b0;
            mem_wren_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            i_ready_reg   <= 1'b0;
            d_ready_reg   <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
`ifdef RISCV_DRAM_ARB_RR_EN
            last_grant_i_reg <= 1'b0;
`endif
        end else begin
            unique case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (grant_next != IDLE) begin
                        state_reg    <= grant_next;
                        mem_addr_reg <= (grant_next == BUSY_I) ? bus.i_addr : bus.d_addr;
                        mem_rden_reg <= (grant_next != BUSY_DW);
                        mem_wren_reg <= (grant_next == BUSY_DW);
                        if (grant_next == BUSY_DW)
                            mem_wdata_reg <= bus.d_wdata;
`ifdef RISCV_DRAM_ARB_RR_EN
                        last_grant_i_reg <= (grant_next == BUSY_I);
`endif
                    end
                end
                BUSY_I, BUSY_DR, BUSY_DW: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    // Last enabled cycle: the DRAM data is valid on this edge.
                    if (cnt_reg == CNT_LAST) begin
                        state_reg    <= DONE;
                        mem_rden_reg <= 1'b0;
                        mem_wren_reg <= 1'b0;
                        if (state_reg == BUSY_I) begin
                            i_rdata_reg <= bus.mem_rdata;
                            i_ready_reg <= 1'b1;
                        end else begin
                            if (state_reg == BUSY_DR)
                                d_rdata_reg <= bus.mem_rdata;
                            d_ready_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    i_ready_reg <= 1'b0;
                    d_ready_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_rden_reg <= 1'b0;
                    mem_wren_reg <= 1'b0;
                    i_ready_reg  <= 1'b0;
                    d_ready_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rden  = mem_rden_reg;
    assign bus.mem_wren  = mem_wren_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.i_ready   = i_ready_reg;
    assign bus.d_ready   = d_ready_reg;
    assign bus.i_rdata   = i_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;

endmodule
